multicycle_controller: RTL and testbench

//  Control FSM for the multicycle RV32I datapath. It consumes opcode/func3/func7 and the zero/negative flags.
//  It drives every datapath select and write enable (PCWrite, IRWrite, RegWrite, MemWrite, muxes, ALUControl).
//  Top level instantiates it beside the datapath, with ports wired name-for-name.

---
 rtl/multicycle_controller_pkg.sv | 84 ++++++++
 rtl/multicycle_controller_alu_decoder.sv | 37 +++
 rtl/multicycle_controller.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Purpose : shared encodings for the multicycle RV32I control path (states, opcodes, selects).
// Latency : n/a (declarations only).
// Backpressure: n/a.
package multicycle_controller_pkg;

  // Sixteen states fill the 4-bit state register exactly.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL1     = 4'd10,
    S_JAL2     = 4'd11,
    S_JALR1    = 4'd12,
    S_JALR2    = 4'd13,
    S_LUI      = 4'd14,
    S_ILLEGAL  = 4'd15
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] ADR_PC     = 2'b00;
  localparam logic [1:0] ADR_RESULT = 2'b01;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  // Immediate format depends only on the opcode, so the datapath can build it every cycle.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    logic [2:0] imm;
    imm = IMM_I;
    case (op)
      OP_STORE:  imm = IMM_S;
      OP_BRANCH: imm = IMM_B;
      OP_JAL:    imm = IMM_J;
      OP_LUI:    imm = IMM_U;
      default:   imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Purpose : maps aluop/func3/func7[5]/opcode[5] to ALUControl and flags unsupported func3.
// Latency : purely combinational.
// Backpressure: none.
// Ports   : aluop_i (ADD/SUB/funct), func3_i, func7_5_i, opcode_5_i (1 = R-type)
//           -> alu_control_o, bad_funct_o (only meaningful when aluop_i is funct).
module multicycle_controller_alu_decoder
  import multicycle_controller_pkg::*;
(
  input  aluop_t     aluop_i,
  input  logic [2:0] func3_i,
  input  logic       func7_5_i,
  input  logic       opcode_5_i,
  output logic [2:0] alu_control_o,
  output logic       bad_funct_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    bad_funct_o   = 1'b0;
    case (aluop_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (func3_i)
          // func7[5] selects SUB only for register-register ops; for ADDI it is immediate data.
          3'b000:  alu_control_o = (opcode_5_i && func7_5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b100:  alu_control_o = ALU_XOR;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: bad_funct_o   = 1'b1;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Purpose : control FSM for the multicycle RV32I datapath; drives every enable and select.
// Latency : 3-5 cycles per instruction (branch/lui 3, R/I/sw/jal/jalr 4, lw 5).
// Backpressure: none; the FSM free-runs, rst low aborts the current instruction.
// Ports   : clk, rst (sync, active low); opcode/func3/func7 from IR; zero/negative from ALU.
//           Outputs PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
//           ResultSrc, ImmSrc, ALUControl, illegal.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       negative,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal
);

  state_t     state_q, state_d;
  aluop_t     aluop;
  logic       bad_funct;
  logic       br_taken, br_bad;
  logic       pc_write, ir_write, reg_write, mem_write, ill;

  // Only func7[5] matters to this control path.
  logic       unused_func7;
  assign unused_func7 = ^{func7[6], func7[4:0]};

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // aluop depends on state alone so the decoder output can feed next-state without a loop.
  assign aluop = (state_q == S_EXECR || state_q == S_EXECI) ? ALUOP_FUNCT :
                 (state_q == S_BRANCH)                      ? ALUOP_SUB   : ALUOP_ADD;

  multicycle_controller_alu_decoder u_alu_dec (
    .aluop_i      (aluop),
    .func3_i      (func3),
    .func7_5_i    (func7[5]),
    .opcode_5_i   (opcode[5]),
    .alu_control_o(ALUControl),
    .bad_funct_o  (bad_funct)
  );

  // Branch condition uses the sign of A-B only; signed overflow is not corrected.
  always_comb begin
    br_taken = 1'b0;
    br_bad   = 1'b0;
    case (func3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = ~zero;
      3'b100:  br_taken = negative;
      3'b101:  br_taken = ~negative;
      default: br_bad   = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    ill       = 1'b0;
    AdrSrc    = ADR_PC;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_B;
    ResultSrc = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        AdrSrc   = ADR_PC;
        ALUSrcA  = SRCA_PC;
        ALUSrcB  = SRCB_FOUR;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut holds PC+4 from FETCH; ALU meanwhile forms OldPC+imm for branch/jal.
        pc_write = 1'b1;
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL1;
          OP_JALR:           state_d = S_JALR1;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = ADR_RESULT;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_MDR;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc    = ADR_RESULT;
        mem_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = (state_q == S_EXECI) ? SRCB_IMM : SRCB_B;
        state_d = bad_funct ? S_ILLEGAL : S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA  = SRCA_A;
        ALUSrcB  = SRCB_B;
        // ResultSrc=ALUOut: the target computed during DECODE.
        pc_write = br_taken & ~br_bad;
        state_d  = br_bad ? S_ILLEGAL : S_FETCH;
      end
      S_JAL1: begin
        pc_write = 1'b1;
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        state_d  = S_JAL2;
      end
      S_JAL2: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JALR1: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        reg_write = 1'b1;
        state_d   = S_JALR2;
      end
      S_JALR2: begin
        // A was latched before rd was written, so rd==rs1 still jumps to the old rs1+imm.
        ALUSrcA   = SRCA_A;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      S_LUI: begin
        ResultSrc = RES_IMM;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_ILLEGAL: begin
        ill     = 1'b1;
        state_d = S_ILLEGAL;
      end
      default: state_d = S_ILLEGAL;
    endcase
  end

  // Enables are gated by rst so an instruction aborted by reset leaves no partial write.
  assign PCWrite  = rst & pc_write;
  assign IRWrite  = rst & ir_write;
  assign RegWrite = rst & reg_write;
  assign MemWrite = rst & mem_write;
  assign illegal  = rst & ill;
  assign ImmSrc   = imm_src_of(opcode);

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zero, negative;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, illegal;
  logic [1:0] AdrSrc, ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ImmSrc, ALUControl;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .zero(zero), .negative(negative),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal)
  );

  // {PCWrite,IRWrite,RegWrite,MemWrite,illegal, AdrSrc,ALUSrcA,ALUSrcB,ResultSrc, ImmSrc, ALUControl}
  logic [18:0] obs;
  assign obs = {PCWrite, IRWrite, RegWrite, MemWrite, illegal,
                AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

  // One entry per clock cycle: the inputs to drive in that cycle and the outputs required.
  typedef struct {
    string       tag;
    logic        rst_n;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        z;
    logic        n;
    logic [18:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  string      cur_name;
  logic       cur_rst;
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic [6:0] cur_f7;
  logic       cur_z, cur_n;
  logic [2:0] cur_imm;

  task automatic push_exp(input string st, input logic [4:0] en, input logic [1:0] adr,
                          input logic [1:0] sa, input logic [1:0] sbs, input logic [1:0] rs,
                          input logic [2:0] alu);
    exp_t x;
    x.tag   = {cur_name, "/", st};
    x.rst_n = cur_rst;
    x.op    = cur_op;
    x.f3    = cur_f3;
    x.f7    = cur_f7;
    x.z     = cur_z;
    x.n     = cur_n;
    x.v     = {en, adr, sa, sbs, rs, cur_imm, alu};
    sb.push_back(x);
  endtask

  // Every instruction starts with the same FETCH and DECODE cycles.
  task automatic instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic z, input logic n, input logic [2:0] imm);
    cur_name = name; cur_rst = 1'b1; cur_op = op; cur_f3 = f3; cur_f7 = f7;
    cur_z = z; cur_n = n; cur_imm = imm;
    push_exp("FETCH",  5'b01000, 2'b00, 2'b00, 2'b10, 2'b00, 3'b000);
    push_exp("DECODE", 5'b10000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
  endtask

  function automatic logic [2:0] alu_ref(input logic rtype, input logic [2:0] f3, input logic f7b);
    case (f3)
      3'b000:  return (rtype && f7b) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b100:  return 3'b100;
      3'b110:  return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  task automatic test_reset();
    cur_name = "reset"; cur_rst = 1'b0; cur_op = 7'b0110011; cur_f3 = 3'b000; cur_f7 = 7'b0;
    cur_z = 1'b0; cur_n = 1'b0; cur_imm = 3'b000;
    push_exp("hold0", 5'b00000, 2'b00, 2'b00, 2'b10, 2'b00, 3'b000);
    push_exp("hold1", 5'b00000, 2'b00, 2'b00, 2'b10, 2'b00, 3'b000);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      rst = e.rst_n; opcode = e.op; func3 = e.f3; func7 = e.f7; zero = e.z; negative = e.n;
      @(negedge clk);
      checks++;
      if (obs !== e.v) begin failures++; $display("FAIL %s got=%b want=%b", e.tag, obs, e.v); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu();
    instr("add", 7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b0, 3'b000);
    push_exp("EXECR", 5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000);
    push_exp("ALUWB", 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    instr("sub", 7'b0110011, 3'b000, 7'b0100000, 1'b0, 1'b0, 3'b000);
    push_exp("EXECR", 5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001);
    push_exp("ALUWB", 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    instr("xori", 7'b0010011, 3'b100, 7'b0000000, 1'b0, 1'b0, 3'b000);
    push_exp("EXECI", 5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b100);
    push_exp("ALUWB", 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    instr("addi_f7", 7'b0010011, 3'b000, 7'b0100000, 1'b0, 1'b0, 3'b000);
    push_exp("EXECI", 5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
    push_exp("ALUWB", 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    instr("and", 7'b0110011, 3'b111, 7'b0000000, 1'b0, 1'b0, 3'b000);
    push_exp("EXECR", 5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b010);
    push_exp("ALUWB", 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      rst = e.rst_n; opcode = e.op; func3 = e.f3; func7 = e.f7; zero = e.z; negative = e.n;
      @(negedge clk);
      checks++;
      if (obs !== e.v) begin failures++; $display("FAIL %s got=%b want=%b", e.tag, obs, e.v); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem();
    instr("lw", 7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b0, 3'b000);
    push_exp("MEMADR",  5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
    push_exp("MEMREAD", 5'b00000, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000);
    push_exp("MEMWB",   5'b00100, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000);
    instr("sw", 7'b0100011, 3'b010, 7'b0000000, 1'b0, 1'b0, 3'b001);
    push_exp("MEMADR",   5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
    push_exp("MEMWRITE", 5'b00010, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      rst = e.rst_n; opcode = e.op; func3 = e.f3; func7 = e.f7; zero = e.z; negative = e.n;
      @(negedge clk);
      checks++;
      if (obs !== e.v) begin failures++; $display("FAIL %s got=%b want=%b", e.tag, obs, e.v); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    instr("beq_z1", 7'b1100011, 3'b000, 7'b0, 1'b1, 1'b0, 3'b010);
    push_exp("BRANCH", 5'b10000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001);
    instr("beq_z0", 7'b1100011, 3'b000, 7'b0, 1'b0, 1'b1, 3'b010);
    push_exp("BRANCH", 5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001);
    instr("bne_z0", 7'b1100011, 3'b001, 7'b0, 1'b0, 1'b0, 3'b010);
    push_exp("BRANCH", 5'b10000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001);
    instr("blt_n1", 7'b1100011, 3'b100, 7'b0, 1'b0, 1'b1, 3'b010);
    push_exp("BRANCH", 5'b10000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001);
    instr("bge_n1", 7'b1100011, 3'b101, 7'b0, 1'b1, 1'b1, 3'b010);
    push_exp("BRANCH", 5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001);
    instr("bge_n0", 7'b1100011, 3'b101, 7'b0, 1'b0, 1'b0, 3'b010);
    push_exp("BRANCH", 5'b10000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      rst = e.rst_n; opcode = e.op; func3 = e.f3; func7 = e.f7; zero = e.z; negative = e.n;
      @(negedge clk);
      checks++;
      if (obs !== e.v) begin failures++; $display("FAIL %s got=%b want=%b", e.tag, obs, e.v); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump();
    instr("jal", 7'b1101111, 3'b000, 7'b0, 1'b0, 1'b0, 3'b011);
    push_exp("JAL1", 5'b10000, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000);
    push_exp("JAL2", 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    instr("jalr", 7'b1100111, 3'b000, 7'b0, 1'b0, 1'b0, 3'b000);
    push_exp("JALR1", 5'b00100, 2'b00, 2'b01, 2'b10, 2'b10, 3'b000);
    push_exp("JALR2", 5'b10000, 2'b00, 2'b10, 2'b01, 2'b10, 3'b000);
    instr("lui", 7'b0110111, 3'b000, 7'b0, 1'b0, 1'b0, 3'b100);
    push_exp("LUI", 5'b00100, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      rst = e.rst_n; opcode = e.op; func3 = e.f3; func7 = e.f7; zero = e.z; negative = e.n;
      @(negedge clk);
      checks++;
      if (obs !== e.v) begin failures++; $display("FAIL %s got=%b want=%b", e.tag, obs, e.v); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    instr("badop", 7'b1111111, 3'b000, 7'b0, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 10; i++)
      push_exp("ILLEGAL", 5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    cur_rst = 1'b0;
    push_exp("rst", 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    instr("badbr", 7'b1100011, 3'b010, 7'b0, 1'b1, 1'b1, 3'b010);
    push_exp("BRANCH",  5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001);
    push_exp("ILLEGAL", 5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    cur_rst = 1'b0;
    push_exp("rst", 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    instr("badr", 7'b0110011, 3'b001, 7'b0, 1'b0, 1'b0, 3'b000);
    push_exp("EXECR",   5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000);
    push_exp("ILLEGAL", 5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    cur_rst = 1'b0;
    push_exp("rst", 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      rst = e.rst_n; opcode = e.op; func3 = e.f3; func7 = e.f7; zero = e.z; negative = e.n;
      @(negedge clk);
      checks++;
      if (obs !== e.v) begin failures++; $display("FAIL %s got=%b want=%b", e.tag, obs, e.v); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midinstr();
    instr("sw_rst", 7'b0100011, 3'b010, 7'b0, 1'b0, 1'b0, 3'b001);
    push_exp("MEMADR", 5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
    cur_rst = 1'b0;
    push_exp("MEMWRITE_rst", 5'b00000, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000);
    instr("add_after", 7'b0110011, 3'b110, 7'b0, 1'b0, 1'b0, 3'b000);
    push_exp("EXECR", 5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b011);
    push_exp("ALUWB", 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      rst = e.rst_n; opcode = e.op; func3 = e.f3; func7 = e.f7; zero = e.z; negative = e.n;
      @(negedge clk);
      checks++;
      if (obs !== e.v) begin failures++; $display("FAIL %s got=%b want=%b", e.tag, obs, e.v); end
      @(posedge clk); #1;
    end
  endtask

  // Random mix of R/I ALU ops with lui interleaved, issued back to back.
  task automatic test_back_to_back();
    logic       rt, f7b;
    logic [2:0] f3;
    logic [2:0] alu;
    int         idx;
    for (int k = 0; k < 8; k++) begin
      rt  = 1'($urandom_range(0, 1));
      f7b = 1'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 4));
      case (idx)
        0:       f3 = 3'b000;
        1:       f3 = 3'b010;
        2:       f3 = 3'b100;
        3:       f3 = 3'b110;
        default: f3 = 3'b111;
      endcase
      alu = alu_ref(rt, f3, f7b);
      instr(rt ? "rnd_r" : "rnd_i", rt ? 7'b0110011 : 7'b0010011, f3, {1'b0, f7b, 5'b0},
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'b000);
      push_exp(rt ? "EXECR" : "EXECI", 5'b00000, 2'b00, 2'b10, rt ? 2'b00 : 2'b01, 2'b00, alu);
      push_exp("ALUWB", 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
      if (k % 3 == 2) begin
        instr("rnd_lui", 7'b0110111, 3'b000, 7'b0, 1'b0, 1'b0, 3'b100);
        push_exp("LUI", 5'b00100, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000);
      end
    end
    while (sb.size() != 0) begin
      e = sb.pop_front();
      rst = e.rst_n; opcode = e.op; func3 = e.f3; func7 = e.f7; zero = e.z; negative = e.n;
      @(negedge clk);
      checks++;
      if (obs !== e.v) begin failures++; $display("FAIL %s got=%b want=%b", e.tag, obs, e.v); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b0; opcode = 7'b0110011; func3 = 3'b000; func7 = 7'b0; zero = 1'b0; negative = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_jump();
    test_illegal();
    test_reset_midinstr();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
